lcd_text_refresh: RTL and testbench
===================================

# lcd_text_refresh

Parametrised HD44780-class character-LCD front end: holds a ROWS×COLS text buffer written by user logic and continuously mirrors it to the panel through the existing byte-level LCD driver (send_en/send_busy handshake). Successor to the fixed two-line, fixed-string top level: geometry, init sequence, power-on delay and update mode are parameters, and text is written at runtime instead of being hard-coded. Sits between application logic and the LCD driver instance.

## Interface
- ROWS, 2: display rows, 1, 2 or 4.
- COLS, 16: columns, 8..40; ROWS*COLS ≤ 80.
- FUNC_SET, 8'h38: first init command, function set.
- POWERON_CYC, 800_000: cycles idled after reset before init (40 ms @ 20 MHz).
- REFRESH_CYC, 20_000_000: frame period in periodic mode; also idle time after each frame.
- UPDATE_MODE, 0: 0 = periodic full redraw; 1 = redraw only when buffer is dirty.
- ACK_TIMEOUT, 1024: cycles allowed for send_busy to rise after send_en.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  buffer write strobe.
- wr_row  in  2  target row.
- wr_col  in  6  target column.
- wr_char  in  8  character code.
- wr_err  out  1  one-cycle pulse: write ignored, out of range.
- send_en  out  1  one-cycle request to driver.
- send_rs  out  1  0 = command, 1 = data.
- send_data  out  8  byte to driver.
- send_busy  in  1  driver busy.
- init_done  out  1  high once init sequence completes; cleared only by rst.
- frame_done  out  1  one-cycle pulse after last character of a frame.
- ack_err  out  1  sticky: a transfer timed out; cleared only by rst.

## Operation
- Buffer: ROWS*COLS bytes, index row*COLS+col; reset fills all cells with 8'h20 (fill may take ROWS*COLS cycles, finished before POWERON_CYC expires). Write with wr_row≥ROWS or wr_col≥COLS: no change, wr_err pulses next cycle.
- Dirty flag: set by every valid write, set by reset, cleared on the cycle a frame starts (SET_ROW for row 0).
- Init commands in order: FUNC_SET, 8'h0C, 8'h06, 8'h01, 8'h80, all rs=0.
- Row base address: row0 8'h00, row1 8'h40, row2 COLS, row3 8'h40+COLS; row select command = 8'h80 | base.
- States: PWR_WAIT → INIT (5 cmds) → SET_ROW → DATA (COLS chars, rs=1) → next row's SET_ROW … → after last row FRAME_WAIT.
- FRAME_WAIT: mode 0 waits REFRESH_CYC cycles then SET_ROW row 0; mode 1 waits REFRESH_CYC then stays until dirty=1, then SET_ROW row 0.
- Every byte goes through ISSUE → WAIT_ACK → WAIT_DONE: ISSUE only when send_busy=0, drives send_en=1 for exactly one cycle with send_rs/send_data; WAIT_ACK until send_busy=1; WAIT_DONE until send_busy=0, then return to caller state with counter advanced.
- Timeout: WAIT_ACK exceeding ACK_TIMEOUT cycles sets ack_err, abandons the byte and restarts at INIT (init_done unchanged).
- Characters are read from the buffer in the ISSUE cycle; a write to the same cell in that cycle yields the old value on the bus and leaves dirty=1, so mode 1 redraws.
- Reset mid-transfer: all state to PWR_WAIT immediately; driver handshake abandoned.

## Timing
- Reset values: send_en=0, send_rs=0, send_data=8'h00, wr_err=0, init_done=0, frame_done=0, ack_err=0.
- First send_en occurs POWERON_CYC+1 cycles after rst deasserts (send_busy=0).
- send_rs/send_data are held stable from the ISSUE cycle until the next ISSUE.
- init_done rises the cycle after WAIT_DONE of the fifth init command.
- frame_done pulses the cycle after WAIT_DONE of the last character of the last row.
- Bytes per frame: ROWS*(COLS+1).
- wr_err latency 1 cycle; valid writes are visible to reads one cycle later.

## Test plan
- ROWS=2, COLS=16, POWERON_CYC=10, driver model busy 5 cycles after each send_en -> first send_en 11 cycles after reset, bytes 38,0C,06,01,80 with rs=0, then init_done=1.
- Mode 0, no writes -> each frame: 80, 16×20 (rs=1), C0, 16×20; frame_done once per frame; frames separated by REFRESH_CYC.
- ROWS=4, COLS=20, write "A" to row2 col0 and "Z" to row3 col19 -> row commands 80,C0,94,D4; data 41 first on row 2, 5A last on row 3.
- Mode 1 -> after first frame no send_en while idle; one write -> exactly one new frame begins after REFRESH_CYC expires.
- Write row=2 with ROWS=2, or col=16 -> wr_err pulse, buffer unchanged in next frame.
- Driver holds send_busy=0 after send_en for ACK_TIMEOUT+1 cycles -> ack_err=1, sequence restarts with FUNC_SET; assert rst mid-frame -> all outputs to reset values next cycle.

Source files
------------

// File: rtl/lcd_text_refresh.sv
// Character-LCD front end: holds a ROWS x COLS text buffer and continuously mirrors
// it to an HD44780-class panel through a byte-level driver (send_en / send_busy).
module lcd_text_refresh #(
   parameter int          ROWS        = 2,
   parameter int          COLS        = 16,
   parameter logic [7:0]  FUNC_SET    = 8'h38,
   parameter int          POWERON_CYC = 800_000,
   parameter int          REFRESH_CYC = 20_000_000,
   parameter int          UPDATE_MODE = 0,
   parameter int          ACK_TIMEOUT = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [1:0] wr_row,
   input  logic [5:0] wr_col,
   input  logic [7:0] wr_char,
   output logic       wr_err,
   output logic       send_en,
   output logic       send_rs,
   output logic [7:0] send_data,
   input  logic       send_busy,
   output logic       init_done,
   output logic       frame_done,
   output logic       ack_err
);

   localparam int CELLS   = ROWS * COLS;
   localparam int IDX_W   = (CELLS > 1) ? $clog2(CELLS) : 1;
   localparam int TMR_MAX = (POWERON_CYC > REFRESH_CYC) ? POWERON_CYC : REFRESH_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int ACK_W   = $clog2(ACK_TIMEOUT + 1);

   localparam logic [TMR_W-1:0] PWR_LAST = TMR_W'(POWERON_CYC - 1);
   localparam logic [TMR_W-1:0] REF_LAST = TMR_W'(REFRESH_CYC - 1);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT);

   typedef enum logic [2:0] {
      S_PWR_WAIT,
      S_INIT,
      S_SET_ROW,
      S_DATA,
      S_FRAME_WAIT,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_DONE
   } state_t;

   state_t state, state_next, ret_state;

   logic [7:0]       buffer [0:CELLS-1];
   logic             dirty;
   logic [TMR_W-1:0] timer;
   logic [ACK_W-1:0] ack_cnt;
   logic [2:0]       init_idx;
   logic [1:0]       row_idx;
   logic [5:0]       col_idx;

   logic             wr_ok;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;
   logic             pwr_done, ref_done, ack_expired;
   logic             last_init, last_col, last_row;
   logic             byte_done;

   function automatic logic [7:0] init_cmd(input logic [2:0] idx);
      case (idx)
         3'd0:    init_cmd = FUNC_SET;
         3'd1:    init_cmd = 8'h0C;
         3'd2:    init_cmd = 8'h06;
         3'd3:    init_cmd = 8'h01;
         default: init_cmd = 8'h80;
      endcase
   endfunction

   // DDRAM row bases: rows 2/3 continue rows 0/1 at offset COLS.
   function automatic logic [7:0] row_cmd(input logic [1:0] row);
      case (row)
         2'd0:    row_cmd = 8'h80;
         2'd1:    row_cmd = 8'hC0;
         2'd2:    row_cmd = 8'h80 | 8'(COLS);
         default: row_cmd = 8'h80 | (8'h40 + 8'(COLS));
      endcase
   endfunction

   assign wr_ok       = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
   assign wr_idx      = IDX_W'(int'(wr_row) * COLS + int'(wr_col));
   assign rd_idx      = IDX_W'(int'(row_idx) * COLS + int'(col_idx));
   assign pwr_done    = (timer == PWR_LAST);
   assign ref_done    = (timer == REF_LAST);
   assign ack_expired = (ack_cnt == ACK_LAST);
   assign last_init   = (init_idx == 3'd4);
   assign last_col    = (int'(col_idx) == COLS - 1);
   assign last_row    = (int'(row_idx) == ROWS - 1);
   assign byte_done   = (state == S_WAIT_DONE) && !send_busy;

   // NOTE: sequential state is written with <= so every register samples the
   // pre-edge value of its neighbours, independent of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) state <= S_PWR_WAIT;
      else     state <= state_next;
   end

   // NOTE: state_next gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         S_PWR_WAIT:   if (pwr_done) state_next = S_INIT;
         S_INIT,
         S_SET_ROW,
         S_DATA:       state_next = S_ISSUE;
         S_FRAME_WAIT: if (ref_done && ((UPDATE_MODE == 0) || dirty)) state_next = S_SET_ROW;
         S_ISSUE:      if (!send_busy) state_next = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (send_busy)        state_next = S_WAIT_DONE;
            else if (ack_expired) state_next = S_INIT;
         end
         S_WAIT_DONE: begin
            if (!send_busy) begin
               case (ret_state)
                  S_INIT:    state_next = last_init ? S_SET_ROW : S_INIT;
                  S_SET_ROW: state_next = S_DATA;
                  default:   state_next = !last_col ? S_DATA :
                                          (last_row ? S_FRAME_WAIT : S_SET_ROW);
               endcase
            end
         end
         default:      state_next = S_PWR_WAIT;
      endcase
   end

   always_comb begin
      send_en = (state == S_ISSUE) && !send_busy;
   end

   // Text buffer, dirty flag and write-error pulse.
   // NOTE: the buffer is a small flop array, so it is cleared to spaces in a single
   // reset cycle rather than by a sequenced fill as a RAM would need.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CELLS; i++) buffer[i] <= 8'h20;
         dirty  <= 1'b1;
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr_en && !wr_ok;
         if (wr_ok) buffer[wr_idx] <= wr_char;
         if (wr_ok)                                          dirty <= 1'b1;
         else if ((state == S_SET_ROW) && (row_idx == 2'd0)) dirty <= 1'b0;
      end
   end

   // Sequencer counters, byte latch and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer      <= '0;
         ack_cnt    <= '0;
         init_idx   <= '0;
         row_idx    <= '0;
         col_idx    <= '0;
         ret_state  <= S_PWR_WAIT;
         send_rs    <= 1'b0;
         send_data  <= 8'h00;
         init_done  <= 1'b0;
         frame_done <= 1'b0;
         ack_err    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_PWR_WAIT: if (!pwr_done) timer <= timer + TMR_W'(1);
            S_INIT: begin
               send_rs   <= 1'b0;
               send_data <= init_cmd(init_idx);
               ret_state <= S_INIT;
            end
            S_SET_ROW: begin
               send_rs   <= 1'b0;
               send_data <= row_cmd(row_idx);
               ret_state <= S_SET_ROW;
            end
            S_DATA: begin
               send_rs   <= 1'b1;
               send_data <= buffer[rd_idx];
               ret_state <= S_DATA;
            end
            S_FRAME_WAIT: if (!ref_done) timer <= timer + TMR_W'(1);
            S_ISSUE:      ack_cnt <= '0;
            S_WAIT_ACK: begin
               if (!send_busy) begin
                  if (ack_expired) begin
                     ack_err  <= 1'b1;
                     init_idx <= '0;
                  end else begin
                     ack_cnt <= ack_cnt + ACK_W'(1);
                  end
               end
            end
            S_WAIT_DONE: begin
               if (byte_done) begin
                  case (ret_state)
                     S_INIT: begin
                        if (last_init) begin
                           init_done <= 1'b1;
                           init_idx  <= '0;
                           row_idx   <= '0;
                           col_idx   <= '0;
                        end else begin
                           init_idx <= init_idx + 3'd1;
                        end
                     end
                     S_SET_ROW: col_idx <= '0;
                     default: begin
                        if (last_col) begin
                           col_idx <= '0;
                           if (last_row) begin
                              row_idx    <= '0;
                              frame_done <= 1'b1;
                              timer      <= '0;
                           end else begin
                              row_idx <= row_idx + 2'd1;
                           end
                        end else begin
                           col_idx <= col_idx + 6'd1;
                        end
                     end
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_text_refresh.sv
// Directed bench: a 2x16 periodic instance and a 4x20 dirty-driven instance, each
// with a simple busy-for-5-cycles driver model and a byte capture queue.
module tb_lcd_text_refresh;

   logic clk;
   logic rst_a, rst_b;

   logic       a_wr_en, a_wr_err, a_send_en, a_send_rs, a_busy, a_init_done, a_frame_done, a_ack_err;
   logic [1:0] a_wr_row;
   logic [5:0] a_wr_col;
   logic [7:0] a_wr_char, a_send_data;
   logic       b_wr_en, b_wr_err, b_send_en, b_send_rs, b_busy, b_init_done, b_frame_done, b_ack_err;
   logic [1:0] b_wr_row;
   logic [5:0] b_wr_col;
   logic [7:0] b_wr_char, b_send_data;

   logic       a_mute;
   int         a_bcnt, b_bcnt;
   logic [8:0] a_q [$];
   logic [8:0] b_q [$];
   int         a_fd_cnt, b_fd_cnt;
   logic [7:0] a_model [32];
   logic [7:0] b_model [80];

   logic [7:0] init_cmds [5] = '{8'h38, 8'h0C, 8'h06, 8'h01, 8'h80};
   logic [7:0] a_base [2]    = '{8'h80, 8'hC0};
   logic [7:0] b_base [4]    = '{8'h80, 8'hC0, 8'h94, 8'hD4};

   int n_checks, n_errors;

   lcd_text_refresh #(
      .ROWS(2), .COLS(16), .FUNC_SET(8'h38), .POWERON_CYC(10),
      .REFRESH_CYC(50), .UPDATE_MODE(0), .ACK_TIMEOUT(8)
   ) dut_a (
      .clk(clk), .rst(rst_a),
      .wr_en(a_wr_en), .wr_row(a_wr_row), .wr_col(a_wr_col), .wr_char(a_wr_char),
      .wr_err(a_wr_err), .send_en(a_send_en), .send_rs(a_send_rs), .send_data(a_send_data),
      .send_busy(a_busy), .init_done(a_init_done), .frame_done(a_frame_done), .ack_err(a_ack_err)
   );

   lcd_text_refresh #(
      .ROWS(4), .COLS(20), .FUNC_SET(8'h38), .POWERON_CYC(10),
      .REFRESH_CYC(40), .UPDATE_MODE(1), .ACK_TIMEOUT(8)
   ) dut_b (
      .clk(clk), .rst(rst_b),
      .wr_en(b_wr_en), .wr_row(b_wr_row), .wr_col(b_wr_col), .wr_char(b_wr_char),
      .wr_err(b_wr_err), .send_en(b_send_en), .send_rs(b_send_rs), .send_data(b_send_data),
      .send_busy(b_busy), .init_done(b_init_done), .frame_done(b_frame_done), .ack_err(b_ack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Driver models: busy for 5 cycles after each accepted send_en.
   always @(posedge clk) begin
      if (rst_a) begin
         a_busy <= 1'b0; a_bcnt <= 0;
      end else if (a_send_en && !a_mute) begin
         a_busy <= 1'b1; a_bcnt <= 5;
      end else if (a_bcnt == 1) begin
         a_busy <= 1'b0; a_bcnt <= 0;
      end else if (a_bcnt != 0) begin
         a_bcnt <= a_bcnt - 1;
      end
   end

   always @(posedge clk) begin
      if (rst_b) begin
         b_busy <= 1'b0; b_bcnt <= 0;
      end else if (b_send_en) begin
         b_busy <= 1'b1; b_bcnt <= 5;
      end else if (b_bcnt == 1) begin
         b_busy <= 1'b0; b_bcnt <= 0;
      end else if (b_bcnt != 0) begin
         b_bcnt <= b_bcnt - 1;
      end
   end

   always @(posedge clk) begin
      if (!rst_a && a_send_en) a_q.push_back({a_send_rs, a_send_data});
      if (!rst_b && b_send_en) b_q.push_back({b_send_rs, b_send_data});
      if (a_frame_done) a_fd_cnt <= a_fd_cnt + 1;
      if (b_frame_done) b_fd_cnt <= b_fd_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [8:0] qbyte(input bit is_b, input int i);
      return is_b ? b_q[i] : a_q[i];
   endfunction

   task automatic check_reset(input bit is_b);
      string p;
      p = is_b ? "b" : "a";
      check({p, "_rst_send_en"},    32'(is_b ? b_send_en    : a_send_en),    32'd0);
      check({p, "_rst_send_rs"},    32'(is_b ? b_send_rs    : a_send_rs),    32'd0);
      check({p, "_rst_send_data"},  32'(is_b ? b_send_data  : a_send_data),  32'd0);
      check({p, "_rst_wr_err"},     32'(is_b ? b_wr_err     : a_wr_err),     32'd0);
      check({p, "_rst_init_done"},  32'(is_b ? b_init_done  : a_init_done),  32'd0);
      check({p, "_rst_frame_done"}, 32'(is_b ? b_frame_done : a_frame_done), 32'd0);
      check({p, "_rst_ack_err"},    32'(is_b ? b_ack_err    : a_ack_err),    32'd0);
   endtask

   task automatic do_write(input bit is_b, input int r, input int c, input logic [7:0] ch,
                           input logic exp_err, input string tag);
      if (is_b) begin
         b_wr_en = 1'b1; b_wr_row = 2'(r); b_wr_col = 6'(c); b_wr_char = ch;
      end else begin
         a_wr_en = 1'b1; a_wr_row = 2'(r); a_wr_col = 6'(c); a_wr_char = ch;
      end
      @(negedge clk);
      a_wr_en = 1'b0;
      b_wr_en = 1'b0;
      check(tag, 32'(is_b ? b_wr_err : a_wr_err), 32'(exp_err));
      if (!exp_err) begin
         if (is_b) b_model[r*20 + c] = ch;
         else      a_model[r*16 + c] = ch;
      end
   endtask

   task automatic count_to_send(input bit is_b, input int limit, output int n);
      n = 0;
      while (!(is_b ? b_send_en : a_send_en) && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_fd(input bit is_b, input int limit, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(is_b ? b_frame_done : a_frame_done) && n < limit);
      check(tag, 32'(is_b ? b_frame_done : a_frame_done), 32'd1);
   endtask

   task automatic check_init(input bit is_b);
      int qs;
      qs = is_b ? b_q.size() : a_q.size();
      if (qs < 5) begin
         check(is_b ? "b_init_len" : "a_init_len", 32'(qs), 32'd5);
         return;
      end
      for (int i = 0; i < 5; i++)
         check(is_b ? "b_init_cmd" : "a_init_cmd", 32'(qbyte(is_b, i)), 32'({1'b0, init_cmds[i]}));
   endtask

   task automatic check_frame(input bit is_b, input int off);
      int rows, cols, qs;
      rows = is_b ? 4 : 2;
      cols = is_b ? 20 : 16;
      qs   = is_b ? b_q.size() : a_q.size();
      if (qs < off + rows*(cols+1)) begin
         check(is_b ? "b_frame_len" : "a_frame_len", 32'(qs), 32'(off + rows*(cols+1)));
         return;
      end
      for (int r = 0; r < rows; r++) begin
         check(is_b ? "b_row_cmd" : "a_row_cmd", 32'(qbyte(is_b, off + r*(cols+1))),
               32'({1'b0, is_b ? b_base[r] : a_base[r]}));
         for (int c = 0; c < cols; c++)
            check(is_b ? "b_char" : "a_char", 32'(qbyte(is_b, off + r*(cols+1) + 1 + c)),
                  32'({1'b1, is_b ? b_model[r*cols + c] : a_model[r*cols + c]}));
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int n;
      n_checks = 0; n_errors = 0;
      a_fd_cnt = 0; b_fd_cnt = 0;
      rst_a = 1'b1; rst_b = 1'b1; a_mute = 1'b0;
      a_wr_en = 1'b0; a_wr_row = '0; a_wr_col = '0; a_wr_char = '0;
      b_wr_en = 1'b0; b_wr_row = '0; b_wr_col = '0; b_wr_char = '0;
      for (int i = 0; i < 32; i++) a_model[i] = 8'h20;
      for (int i = 0; i < 80; i++) b_model[i] = 8'h20;

      repeat (3) @(negedge clk);
      check_reset(1'b0);

      // Power-on delay, init sequence and first full frame.
      rst_a = 1'b0;
      count_to_send(1'b0, 100, n);
      check("a_first_send_lat", 32'(n), 32'd11);
      wait_fd(1'b0, 2000, "a_frame1_done");
      check("a_init_done", 32'(a_init_done), 32'd1);
      check("a_frame1_len", 32'(a_q.size()), 32'd39);
      check_init(1'b0);
      check_frame(1'b0, 5);

      // Periodic redraw spacing and second frame.
      count_to_send(1'b0, 200, n);
      check("a_frame_gap", 32'(n), 32'd51);
      a_q.delete();
      wait_fd(1'b0, 2000, "a_frame2_done");
      check("a_frame2_len", 32'(a_q.size()), 32'd34);
      check_frame(1'b0, 0);
      @(negedge clk);
      check("a_fd_width", 32'(a_frame_done), 32'd0);
      check("a_fd_count", 32'(a_fd_cnt), 32'd2);

      // Out-of-range writes are dropped; one valid write.
      a_q.delete();
      do_write(1'b0, 2, 0,  8'h58, 1'b1, "a_wr_err_row");
      do_write(1'b0, 0, 16, 8'h59, 1'b1, "a_wr_err_col");
      do_write(1'b0, 1, 5,  8'h51, 1'b0, "a_wr_ok");
      wait_fd(1'b0, 2000, "a_frame3_done");
      check("a_frame3_len", 32'(a_q.size()), 32'd34);
      check_frame(1'b0, 0);

      // Handshake timeout: driver never acknowledges the next byte.
      a_mute = 1'b1;
      a_q.delete();
      count_to_send(1'b0, 200, n);
      n = 0;
      while (!a_ack_err && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("a_ack_lat", 32'(n), 32'd10);
      a_mute = 1'b0;
      a_q.delete();
      check("a_init_done_kept", 32'(a_init_done), 32'd1);
      wait_fd(1'b0, 2000, "a_frame4_done");
      check("a_frame4_len", 32'(a_q.size()), 32'd39);
      check_init(1'b0);
      check_frame(1'b0, 5);
      check("a_ack_err_sticky", 32'(a_ack_err), 32'd1);

      // Reset in the middle of a frame.
      a_q.delete();
      n = 0;
      while (a_q.size() < 8 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("a_midframe_reached", 32'(a_q.size() >= 8), 32'd1);
      rst_a = 1'b1;
      @(negedge clk);
      check_reset(1'b0);
      rst_a = 1'b0;
      count_to_send(1'b0, 100, n);
      check("a_restart_lat", 32'(n), 32'd11);
      check("a_restart_cmd", 32'({a_send_rs, a_send_data}), 32'h038);

      // 4x20 geometry, dirty-driven updates.
      check_reset(1'b1);
      rst_b = 1'b0;
      do_write(1'b1, 2, 0,  8'h41, 1'b0, "b_wr_a");
      do_write(1'b1, 3, 19, 8'h5A, 1'b0, "b_wr_z");
      do_write(1'b1, 0, 20, 8'h3F, 1'b1, "b_wr_err_col");
      wait_fd(1'b1, 3000, "b_frame1_done");
      check("b_init_done", 32'(b_init_done), 32'd1);
      check("b_frame1_len", 32'(b_q.size()), 32'd89);
      check_init(1'b1);
      check_frame(1'b1, 5);
      if (b_q.size() >= 89) begin
         check("b_row2_first", 32'(b_q[48]), 32'h141);
         check("b_row3_last",  32'(b_q[88]), 32'h15A);
      end

      b_q.delete();
      repeat (120) @(negedge clk);
      check("b_idle_no_send", 32'(b_q.size()), 32'd0);
      do_write(1'b1, 0, 0, 8'h42, 1'b0, "b_wr_b");
      wait_fd(1'b1, 3000, "b_frame2_done");
      check("b_frame2_len", 32'(b_q.size()), 32'd84);
      check_frame(1'b1, 0);
      b_q.delete();
      repeat (120) @(negedge clk);
      check("b_idle_after_redraw", 32'(b_q.size()), 32'd0);
      check("b_fd_count", 32'(b_fd_cnt), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
